bus_fabric: RTL and testbench

Parametrised address decoder and bus controller between the CPU and N memory-mapped slaves (RAM, GPU, LEDs, future peripherals). It replaces fixed chip-select equations with configurable base/mask regions. Each slave gets per-slave wait states and a ready handshake, and the fabric adds timeout and unmapped-access error reporting. Sits directly under the board top level; the CPU stalls on `cpu_ready`.

---
 rtl/bus_fabric_pkg.sv | 28 ++
 rtl/bus_region_decode.sv | 29 ++
 rtl/bus_fabric.sv | 202 ++++++++++++++++++++
 tb/tb_bus_fabric.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_fabric_pkg.sv
// Shared types and constants for the CPU-to-slave bus fabric.
// Default regions: RAM low half, GPU at 0x8000, LEDs at 0xA000, spare at 0xC000.
package bus_fabric_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_UNMAPPED = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_RW       = 2'd3;

    localparam logic [63:0] DEF_BASE = {16'hC000, 16'hA000, 16'h8000, 16'h0000};
    localparam logic [63:0] DEF_MASK = {16'hF000, 16'hF000, 16'hF000, 16'h8000};
    localparam logic [15:0] DEF_WAIT = {4'd2, 4'd0, 4'd1, 4'd0};

    // True when addr falls inside the region described by base/mask.
    function automatic logic region_hit(input logic [63:0] addr,
                                        input logic [63:0] base,
                                        input logic [63:0] mask);
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/bus_region_decode.sv
// Combinational base/mask address decoder; the lowest matching slave index wins.
module bus_region_decode
    import bus_fabric_pkg::*;
#(
    parameter int                  ADDR_W = 16,
    parameter int                  N      = 4,
    parameter logic [N*ADDR_W-1:0] BASE   = DEF_BASE,
    parameter logic [N*ADDR_W-1:0] MASK   = DEF_MASK
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [N-1:0]      hit_o,
    output logic              hit_valid_o
);

    always_comb begin
        hit_o       = '0;
        hit_valid_o = 1'b0;
        // Scan from the top so a lower index overrides any higher one.
        for (int i = N - 1; i >= 0; i--) begin
            if (region_hit(64'(addr_i), 64'(BASE[i*ADDR_W +: ADDR_W]),
                           64'(MASK[i*ADDR_W +: ADDR_W]))) begin
                hit_o       = '0;
                hit_o[i]    = 1'b1;
                hit_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// Bus controller: decodes CPU requests to N slaves with wait states, ready
// handshake, timeout and sticky error reporting.
module bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter int                  ADDR_W  = 16,
    parameter int                  DATA_W  = 8,
    parameter int                  N       = 4,
    parameter logic [N*ADDR_W-1:0] BASE    = DEF_BASE,
    parameter logic [N*ADDR_W-1:0] MASK    = DEF_MASK,
    parameter logic [N*4-1:0]      WAIT    = DEF_WAIT,
    parameter int                  TIMEOUT = 15
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_wdata_i,
    input  logic                cpu_read_i,
    input  logic                cpu_write_i,
    output logic [DATA_W-1:0]   cpu_rdata_o,
    output logic                cpu_ready_o,
    output logic [N-1:0]        slv_sel_o,
    output logic [ADDR_W-1:0]   slv_addr_o,
    output logic [DATA_W-1:0]   slv_wdata_o,
    output logic                slv_read_o,
    output logic                slv_write_o,
    input  logic [N*DATA_W-1:0] slv_rdata_i,
    input  logic [N-1:0]        slv_ready_i,
    input  logic                err_clear_i,
    output logic                bus_error_o,
    output logic [ADDR_W-1:0]   err_addr_o,
    output logic [1:0]          err_code_o
);

    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT);

    state_e              state_q;
    logic [N-1:0]        sel_q;
    logic                rd_q, wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic                cpu_ready_q;
    logic [3:0]          cnt_q;
    logic [7:0]          tmo_q;
    logic                bus_error_q, bus_error_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [1:0]          err_code_q, err_code_d;

    logic [N-1:0]        dec_hit;
    logic                dec_valid;
    logic                req;
    logic [3:0]          wait_sel;
    logic                ready_sel;
    logic [DATA_W-1:0]   rdata_sel;
    logic [1:0]          err_new;
    logic [ADDR_W-1:0]   err_addr_new;

    bus_region_decode #(
        .ADDR_W (ADDR_W),
        .N      (N),
        .BASE   (BASE),
        .MASK   (MASK)
    ) u_decode (
        .addr_i      (cpu_addr_i),
        .hit_o       (dec_hit),
        .hit_valid_o (dec_valid)
    );

    assign req = cpu_read_i | cpu_write_i;

    always_comb begin
        wait_sel  = '0;
        ready_sel = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (dec_hit[i]) wait_sel = WAIT[i*4 +: 4];
            if (sel_q[i]) begin
                ready_sel = slv_ready_i[i];
                rdata_sel = slv_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        err_new      = ERR_NONE;
        err_addr_new = addr_q;
        if (state_q == ST_IDLE && req) begin
            err_addr_new = cpu_addr_i;
            if (cpu_read_i && cpu_write_i) err_new = ERR_RW;
            else if (!dec_valid)           err_new = ERR_UNMAPPED;
        end else if (state_q == ST_ACCESS && !ready_sel && tmo_q == 8'd0) begin
            err_new = ERR_TIMEOUT;
        end
    end

    // A clear in the same cycle as a fresh error still lets the error land.
    always_comb begin
        bus_error_d = bus_error_q;
        err_addr_d  = err_addr_q;
        err_code_d  = err_code_q;
        if (err_clear_i) begin
            bus_error_d = 1'b0;
            err_addr_d  = '0;
            err_code_d  = ERR_NONE;
        end
        if (err_new != ERR_NONE && (!bus_error_q || err_clear_i)) begin
            bus_error_d = 1'b1;
            err_addr_d  = err_addr_new;
            err_code_d  = err_new;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus_error_q <= 1'b0;
            err_addr_q  <= '0;
            err_code_q  <= ERR_NONE;
        end else begin
            bus_error_q <= bus_error_d;
            err_addr_q  <= err_addr_d;
            err_code_q  <= err_code_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            cnt_q       <= '0;
            tmo_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        addr_q  <= cpu_addr_i;
                        wdata_q <= cpu_wdata_i;
                        if (err_new != ERR_NONE) begin
                            cpu_rdata_q <= '1;
                            state_q     <= ST_DONE;
                        end else begin
                            sel_q   <= dec_hit;
                            rd_q    <= cpu_read_i;
                            wr_q    <= cpu_write_i;
                            cnt_q   <= wait_sel;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        tmo_q   <= TMO_LOAD;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (ready_sel || tmo_q == 8'd0) begin
                        if (!ready_sel)  cpu_rdata_q <= '1;
                        else if (rd_q)   cpu_rdata_q <= rdata_sel;
                        sel_q       <= '0;
                        rd_q        <= 1'b0;
                        wr_q        <= 1'b0;
                        cpu_ready_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        tmo_q <= tmo_q - 8'd1;
                    end
                end
                ST_DONE: begin
                    // Decode-time errors arrive here without the pulse and raise it one cycle later.
                    if (cpu_ready_q) begin
                        cpu_ready_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        cpu_ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cpu_rdata_o = cpu_rdata_q;
    assign cpu_ready_o = cpu_ready_q;
    assign slv_sel_o   = sel_q;
    assign slv_addr_o  = addr_q;
    assign slv_wdata_o = wdata_q;
    assign slv_read_o  = rd_q;
    assign slv_write_o = wr_q;
    assign bus_error_o = bus_error_q;
    assign err_addr_o  = err_addr_q;
    assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Directed vector bench for bus_fabric with a small sticky-error model.
module tb_bus_fabric;

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_read, cpu_write;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic [3:0]  slv_sel;
    logic [15:0] slv_addr;
    logic [7:0]  slv_wdata;
    logic        slv_read, slv_write;
    logic [31:0] slv_rdata;
    logic [3:0]  slv_ready;
    logic        err_clear;
    logic        bus_error;
    logic [15:0] err_addr;
    logic [1:0]  err_code;

    int errors = 0;
    int checks = 0;

    logic        m_err;
    logic [1:0]  m_code;
    logic [15:0] m_addr;

    bus_fabric #(
        .ADDR_W  (16),
        .DATA_W  (8),
        .N       (4),
        .BASE    (64'h0100_A000_8000_0000),
        .MASK    (64'hFF00_F000_F000_8000),
        .WAIT    (16'h1300),
        .TIMEOUT (15)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_read_i  (cpu_read),
        .cpu_write_i (cpu_write),
        .cpu_rdata_o (cpu_rdata),
        .cpu_ready_o (cpu_ready),
        .slv_sel_o   (slv_sel),
        .slv_addr_o  (slv_addr),
        .slv_wdata_o (slv_wdata),
        .slv_read_o  (slv_read),
        .slv_write_o (slv_write),
        .slv_rdata_i (slv_rdata),
        .slv_ready_i (slv_ready),
        .err_clear_i (err_clear),
        .bus_error_o (bus_error),
        .err_addr_o  (err_addr),
        .err_code_o  (err_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [3:0]  rdy;
        logic        clr;
        logic [3:0]  exp_sel;
        logic [7:0]  exp_rdata;
        int          exp_lat;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("err_clear flag", 32'(bus_error), 32'd0);
        chk("err_clear code", 32'(err_code), 32'd0);
        m_err  = 1'b0;
        m_code = 2'd0;
        m_addr = 16'h0;
    endtask

    task automatic run_vec(input vec_t v);
        int          lat;
        logic [3:0]  sel1;
        logic        rd1, wr1;
        logic [7:0]  wd1;
        logic [15:0] ad1;
        logic [7:0]  rdata;
        logic        has_sel;
        sel1 = '0; rd1 = 1'b0; wr1 = 1'b0; wd1 = '0; ad1 = '0;
        if (v.clr) pulse_clear();
        slv_ready = v.rdy;
        @(negedge clk);
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        cpu_read  = v.rd;
        cpu_write = v.wr;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                sel1 = slv_sel; rd1 = slv_read; wr1 = slv_write;
                wd1 = slv_wdata; ad1 = slv_addr;
            end
        end while (!cpu_ready && lat < 60);
        rdata = cpu_rdata;
        has_sel = (v.exp_sel != 4'd0);
        chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({v.name, " sel"}, 32'(sel1), 32'(v.exp_sel));
        chk({v.name, " slv_read"}, 32'(rd1), 32'(v.rd & !v.wr & has_sel));
        chk({v.name, " slv_write"}, 32'(wr1), 32'(v.wr & !v.rd & has_sel));
        chk({v.name, " slv_addr"}, 32'(ad1), 32'(v.addr));
        if (v.wr && has_sel) chk({v.name, " slv_wdata"}, 32'(wd1), 32'(v.wdata));
        if (v.rd) chk({v.name, " rdata"}, 32'(rdata), 32'(v.exp_rdata));
        @(negedge clk);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        @(posedge clk);
        #1;
        chk({v.name, " ready width"}, 32'(cpu_ready), 32'd0);
        if (v.exp_code != 2'd0 && !m_err) begin
            m_err  = 1'b1;
            m_code = v.exp_code;
            m_addr = v.addr;
        end
        chk({v.name, " bus_error"}, 32'(bus_error), 32'(m_err));
        chk({v.name, " err_code"}, 32'(err_code), 32'(m_code));
        chk({v.name, " err_addr"}, 32'(err_addr), 32'(m_addr));
    endtask

    initial begin
        int   lat;
        logic saw_ready;
        vec_t post;

        //          name           rd    wr    addr      wdata  rdy      clr   sel      rdata  lat code
        vecs[0] = '{"ram_rd",      1'b1, 1'b0, 16'h1234, 8'h00, 4'hF,    1'b0, 4'b0001, 8'h5A, 3,  2'd0};
        vecs[1] = '{"led_wr",      1'b0, 1'b1, 16'hA010, 8'hA5, 4'hF,    1'b0, 4'b0100, 8'h00, 6,  2'd0};
        vecs[2] = '{"unmapped",    1'b1, 1'b0, 16'h9000, 8'h00, 4'hF,    1'b0, 4'b0000, 8'hFF, 2,  2'd1};
        vecs[3] = '{"timeout",     1'b1, 1'b0, 16'h8004, 8'h00, 4'b1101, 1'b1, 4'b0010, 8'hFF, 18, 2'd2};
        vecs[4] = '{"second_err",  1'b1, 1'b0, 16'hF000, 8'h00, 4'hF,    1'b0, 4'b0000, 8'hFF, 2,  2'd1};
        vecs[5] = '{"overlap",     1'b1, 1'b0, 16'h0100, 8'h00, 4'hF,    1'b0, 4'b0001, 8'h5A, 3,  2'd0};
        vecs[6] = '{"rw_both",     1'b1, 1'b1, 16'h0100, 8'h11, 4'hF,    1'b1, 4'b0000, 8'hFF, 2,  2'd3};
        vecs[7] = '{"gpu_rd",      1'b1, 1'b0, 16'h8FFF, 8'h00, 4'hF,    1'b0, 4'b0010, 8'h3C, 3,  2'd0};
        vecs[8] = '{"led_rd",      1'b1, 1'b0, 16'hAFFF, 8'h00, 4'hF,    1'b0, 4'b0100, 8'h77, 6,  2'd0};
        vecs[9] = '{"unmapped_wr", 1'b0, 1'b1, 16'h9000, 8'h42, 4'hF,    1'b1, 4'b0000, 8'h00, 2,  2'd1};
        post    = '{"post_reset",  1'b1, 1'b0, 16'h1234, 8'h00, 4'hF,    1'b0, 4'b0001, 8'h5A, 3,  2'd0};

        m_err = 1'b0; m_code = 2'd0; m_addr = 16'h0;
        rst_n = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_read = 1'b0; cpu_write = 1'b0;
        slv_rdata = {8'h99, 8'h77, 8'h3C, 8'h5A};
        slv_ready = 4'hF;
        err_clear = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset cpu_ready", 32'(cpu_ready), 32'd0);
        chk("reset cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("reset strobes", 32'({slv_sel, slv_read, slv_write}), 32'd0);
        chk("reset slv_addr/wdata", 32'({slv_addr, slv_wdata}), 32'd0);
        chk("reset error regs", 32'({bus_error, err_addr, err_code}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Ready held low for two ACCESS cycles; a mid-transaction address change is ignored.
        pulse_clear();
        slv_ready = 4'b1110;
        @(negedge clk);
        cpu_addr = 16'h0042;
        cpu_read = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 2) cpu_addr = 16'h9000;
            if (lat == 4) begin
                chk("stall strobe held", 32'(slv_read), 32'd1);
                slv_ready[0] = 1'b1;
            end
        end while (!cpu_ready && lat < 60);
        chk("stall latency", 32'(lat), 32'd5);
        chk("stall rdata", 32'(cpu_rdata), 32'h5A);
        chk("stall latched addr", 32'(slv_addr), 32'h0042);
        @(negedge clk);
        cpu_read = 1'b0;
        @(posedge clk);
        #1;
        chk("stall no error", 32'(bus_error), 32'd0);

        // Force a sticky error so the reset below must also clear it.
        run_vec(vecs[2]);

        // Asynchronous reset while the LED write sits in its wait states.
        @(negedge clk);
        cpu_addr  = 16'hA020;
        cpu_wdata = 8'h3C;
        cpu_write = 1'b1;
        @(posedge clk);
        #1;
        chk("pre-reset slv_write", 32'(slv_write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset strobes", 32'({slv_sel, slv_write, slv_read}), 32'd0);
        cpu_write = 1'b0;
        saw_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (cpu_ready) saw_ready = 1'b1;
        end
        chk("reset no cpu_ready", 32'(saw_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_err = 1'b0; m_code = 2'd0; m_addr = 16'h0;
        run_vec(post);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule
